// File: rtl/smpl_queue.sv
// smpl_queue: stereo circular sample window feeding one FIR band.
// Keeps the most recent TAPS {lft,rght} samples in a DEPTH-entry synchronous
// RAM. Each write that leaves the window full starts a burst: one SETUP cycle
// showing the oldest sample, then TAPS STREAM cycles presenting the window
// oldest-to-newest. Writes that arrive mid-burst are held in a one-entry
// pending register; a further write while it is occupied is dropped.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wrt_smpl            one-cycle strobe, sample on lft_in/rght_in
//   lft_in, rght_in     16-bit two's complement samples
//   sequencing          high for the TAPS+1 cycle burst
//   lft_out, rght_out   registered sample stream (holds last value when idle)
//   full                window has held TAPS samples since reset
//   overrun             sticky, a sample was dropped
module smpl_queue #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned TAPS  = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        full,
  output logic        overrun
);

  localparam int unsigned SW = 16;
  localparam int unsigned DW = 2 * SW;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   new_ptr_q, new_ptr_d;
  logic [PW-1:0]   old_ptr_q, old_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   k_q, k_d;
  logic            pend_vld_q, pend_vld_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            seq_q, seq_d;
  logic [DW-1:0]   out_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            acc_c;
  logic            we_c;
  logic [DW-1:0]   wdata_c;
  logic            re_c;
  logic [PW-1:0]   raddr_c;
  logic            byp_c;
  logic [DW-1:0]   in_c;

  // Pointer increment with explicit wrap, valid for any DEPTH
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_c = {lft_in, rght_in};

  // Next-state, write/read control and pending handling
  always_comb begin
    state_d    = state_q;
    new_ptr_d  = new_ptr_q;
    old_ptr_d  = old_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    full_d     = full_q;
    overrun_d  = overrun_q;
    acc_c      = 1'b0;
    we_c       = 1'b0;
    wdata_c    = in_c;
    re_c       = 1'b0;
    raddr_c    = rd_ptr_q;
    byp_c      = 1'b0;

    case (state_q)
      IDLE: begin
        // A held sample takes priority; a coincident new sample refills pending
        if (pend_vld_q) begin
          acc_c      = 1'b1;
          wdata_c    = pend_q;
          pend_vld_d = wrt_smpl;
          if (wrt_smpl) pend_d = in_c;
        end else if (wrt_smpl) begin
          acc_c = 1'b1;
        end

        if (acc_c) begin
          we_c      = 1'b1;
          new_ptr_d = ptr_inc(new_ptr_q);
          if (cnt_q != CW'(TAPS)) cnt_d = cnt_q + CW'(1);
          else                    old_ptr_d = ptr_inc(old_ptr_q);

          if (cnt_d == CW'(TAPS)) begin
            // Fetch the oldest sample now so SETUP shows it immediately
            state_d  = SETUP;
            full_d   = 1'b1;
            re_c     = 1'b1;
            raddr_c  = old_ptr_d;
            rd_ptr_d = old_ptr_d;
            byp_c    = (old_ptr_d == new_ptr_q);
          end
        end
      end

      SETUP: begin
        re_c     = 1'b1;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        k_d      = '0;
        state_d  = STREAM;
      end

      STREAM: begin
        // Read one ahead: the edge ending cycle k loads sample k+1
        if (k_q == CW'(TAPS - 1)) begin
          state_d = IDLE;
        end else begin
          re_c     = 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q);
          k_d      = k_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && wrt_smpl) begin
      if (pend_vld_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = in_c;
      end
    end

    seq_d = (state_d != IDLE);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      new_ptr_q  <= '0;
      old_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      seq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      seq_q      <= seq_d;
    end
  end

  // Sample storage write port
  always_ff @(posedge clk) begin
    if (we_c && rst_n) mem[new_ptr_q] <= wdata_c;
  end

  // Synchronous read port doubling as the output register; bypass covers
  // the single-sample window where oldest and newest share an address
  always_ff @(posedge clk) begin
    if (!rst_n)    out_q <= '0;
    else if (re_c) out_q <= byp_c ? wdata_c : mem[raddr_c];
  end

  assign sequencing = seq_q;
  assign lft_out    = out_q[DW-1:SW];
  assign rght_out   = out_q[SW-1:0];
  assign full       = full_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_smpl_queue.sv
// tb_smpl_queue: scoreboard bench for smpl_queue at DEPTH=8, TAPS=5.
// The driver applies directed then random writes and steps a window/queue
// reference model per clock edge; the model pushes expected burst samples into
// a scoreboard queue that a negedge monitor pops whenever sequencing is high.
module tb_smpl_queue;

  localparam int DEPTH = 8;
  localparam int TAPS  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        full;
  logic        overrun;

  smpl_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_in     (lft_in),
    .rght_in    (rght_in),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .full       (full),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] win[$];
  logic [31:0] exp_q[$];
  logic        pend_v;
  logic [31:0] pend;
  logic        ovr;
  int          busy;
  int          rst_epoch;

  // Monitor state
  bit          mon_en;
  int          seen_epoch;
  logic [31:0] last_out;
  logic [31:0] exp_d;

  int nvec;
  int nerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // One clock edge of the reference model: a full window after an accepted
  // write schedules a burst of oldest + whole window, lasting TAPS+1 edges
  task automatic model_edge(input logic rst, input logic wr, input logic [31:0] d);
    logic        have;
    logic [31:0] x;
    if (!rst) begin
      win.delete();
      exp_q.delete();
      pend_v = 1'b0;
      ovr    = 1'b0;
      busy   = 0;
      rst_epoch++;
      return;
    end
    if (busy > 0) begin
      if (wr) begin
        if (pend_v) ovr = 1'b1;
        else begin pend_v = 1'b1; pend = d; end
      end
      busy--;
    end else begin
      have = 1'b0;
      x    = d;
      if (pend_v) begin
        x = pend; have = 1'b1;
        pend_v = wr;
        if (wr) pend = d;
      end else if (wr) begin
        have = 1'b1;
      end
      if (have) begin
        win.push_back(x);
        if (win.size() > TAPS) void'(win.pop_front());
        if (win.size() == TAPS) begin
          exp_q.push_back(win[0]);
          for (int i = 0; i < win.size(); i++) exp_q.push_back(win[i]);
          busy = TAPS + 1;
        end
      end
    end
  endtask

  task automatic tick(input logic wr, input logic [15:0] l, input logic [15:0] r);
    wrt_smpl = wr;
    lft_in   = l;
    rght_in  = r;
    @(posedge clk);
    model_edge(rst_n, wr, {l, r});
    #1;
    wrt_smpl = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 16'h0);
  endtask

  task automatic wr_lr(input int v);
    tick(1'b1, 16'(v), 16'(v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 16'h0, 16'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT is sequencing
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_epoch != seen_epoch) begin
        last_out   = '0;
        seen_epoch = rst_epoch;
      end
      chk("sequencing", 32'(sequencing), 32'(busy > 0));
      chk("full", 32'(full), 32'(win.size() == TAPS));
      chk("overrun", 32'(overrun), 32'(ovr));
      if (sequencing) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL burst_data at %0t: got %h, expected no burst", $time, {lft_out, rght_out});
        end else begin
          exp_d = exp_q.pop_front();
          chk("burst_data", {lft_out, rght_out}, exp_d);
          last_out = exp_d;
        end
      end else begin
        chk("idle_data", {lft_out, rght_out}, last_out);
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    wrt_smpl   = 1'b0;
    lft_in     = '0;
    rght_in    = '0;
    pend_v     = 1'b0;
    pend       = '0;
    ovr        = 1'b0;
    busy       = 0;
    rst_epoch  = 0;
    seen_epoch = 0;
    last_out   = '0;
    mon_en     = 1'b0;
    nvec       = 0;
    nerr       = 0;

    do_reset();
    idle(2);

    // Three writes: no burst, outputs stay zero
    for (int v = 1; v <= 3; v++) begin wr_lr(v); idle(3); end
    idle(5);

    // Fill the window: burst 1,1,2,3,4,5
    for (int v = 4; v <= 5; v++) begin wr_lr(v); idle(3); end
    idle(10);

    // Steady-state bursts across pointer wrap
    for (int v = 6; v <= 10; v++) begin wr_lr(v); idle(19); end

    // One write mid-stream goes to pending, next burst follows after one idle
    wr_lr(11);
    idle(3);
    wr_lr(12);
    idle(20);

    // Second write mid-burst is dropped and overrun latches
    wr_lr(13);
    idle(2);
    wr_lr(14);
    idle(1);
    wr_lr(15);
    idle(20);

    // Reset in STREAM cycle 2, then four writes never fill the window
    wr_lr(16);
    idle(3);
    do_reset();
    idle(2);
    for (int v = 17; v <= 20; v++) begin wr_lr(v); idle(2); end
    idle(10);

    // Randomized traffic with random data and mixed write density
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i < 750) tick(1'($urandom_range(0, 6) == 0), 16'($urandom), 16'($urandom));
      else         tick(1'($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
    end
    idle(3 * (TAPS + 2));

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/smpl_queue.md
# smpl_queue

Stereo circular sample queue that sits directly upstream of the FIR filter stages. It stores the most recent TAPS stereo samples. Once the window is full, each new sample triggers a burst: `sequencing` is raised and the window is streamed oldest-to-newest on `lft_out`/`rght_out`, which is exactly the framing a FIR multiply-accumulate stage consumes. One queue instance feeds each FIR band.

## Interface
- DEPTH, 1024: storage entries; any value ≥ TAPS+1 (wrap is explicit, not power-of-2 dependent)
- TAPS, 1021: samples per burst; equals the filter coefficient count
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- wrt_smpl  in  1  one-cycle strobe: new stereo sample present on lft_in/rght_in
- lft_in  in  16  left sample, two's complement
- rght_in  in  16  right sample, two's complement
- sequencing  out  1  high for the whole burst (TAPS+1 consecutive cycles)
- lft_out  out  16  left sample stream to FIR
- rght_out  out  16  right sample stream to FIR
- full  out  1  window holds TAPS samples; stays high until reset
- overrun  out  1  sticky: a sample was dropped; cleared only by reset

## Operation
- Storage is DEPTH x 32 bits, holding {lft,rght}. Use a synchronous-read RAM.
- The write pointer `new_ptr` and oldest pointer `old_ptr` advance +1 and wrap from DEPTH-1 to 0.
- The fill counter `cnt` has range 0..TAPS.
- Accepted write, when not bursting:
  - store at new_ptr, then new_ptr+1.
  - if cnt < TAPS: cnt+1.
  - if cnt == TAPS (already full): old_ptr+1, so the oldest sample is discarded.
- Burst start: a burst starts after any accepted write that leaves cnt == TAPS. This includes the write that first fills the window.
- Writes with cnt < TAPS after the write never start a burst.
- FSM states: IDLE, SETUP, STREAM.
  - IDLE: on an accepted write with resulting cnt == TAPS, go to SETUP. Otherwise stay in IDLE.
  - SETUP, 1 cycle: sequencing=1. Outputs show the oldest sample; the downstream FIR uses this cycle to clear its accumulator. Go to STREAM.
  - STREAM, TAPS cycles: sequencing=1. In STREAM cycle k (k=0..TAPS-1), outputs = sample old_ptr+k (mod DEPTH). After cycle TAPS-1, go to IDLE.
- wrt_smpl during SETUP or STREAM:
  - the sample is latched into a one-entry pending register.
  - on return to IDLE, the pending sample is written as if it had just arrived, starting the next burst with the same latency as a direct write.
  - a second wrt_smpl while the pending entry is occupied is dropped, and overrun is set.
- wrt_smpl in the same cycle the pending entry is consumed (first IDLE cycle): the new sample goes into pending, which then holds the new sample. No overrun.
- In IDLE, lft_out/rght_out hold the last streamed value. sequencing=0.

## Timing
- Reset values: sequencing=0, lft_out=0, rght_out=0, full=0, overrun=0, cnt=0, both pointers 0, pending empty, state IDLE.
- Reset mid-burst: sequencing drops the cycle after the rst_n=0 edge, and all stored contents are treated as empty.
- Burst latency: wrt_smpl sampled high at edge E0. SETUP is the cycle after E0 (sequencing rises at E0+1 edge output). The stream occupies the next TAPS cycles, so sequencing is high for exactly TAPS+1 cycles and then low for at least 1 cycle.
- Pending write latency: processed at the first IDLE edge, so at least one sequencing=0 cycle separates bursts.
- Outputs are registered; RAM read address is issued one cycle ahead of use so that each STREAM cycle k presents its sample with no bubbles.
- full rises with the edge that writes the TAPS-th sample, which is the same edge that starts the first burst.
- No arithmetic on data; samples pass bit-exact. Counter widths are $clog2(DEPTH) and $clog2(TAPS+1).

## Test plan
- Reset, then 3 writes at DEPTH=8, TAPS=5 -> sequencing never rises, full=0, outputs stay 0x0000.
- DEPTH=8, TAPS=5, write L=R=1..5 -> 5th write gives sequencing for 6 cycles; outputs 1,1,2,3,4,5 (SETUP then STREAM); full=1.
- Continue with writes 6..10, spaced 20 cycles apart -> each produces a burst ending in the newest 5 samples, e.g. after 9: 5,5,6,7,8,9. Checks pointer wrap past entry 7.
- Write during STREAM -> the current burst is unaltered; the next burst begins after 1 idle cycle and contains the new sample last; overrun=0.
- Two writes during one burst -> the second is dropped, overrun=1 until reset, and the following burst contains only the first.
- Drive rst_n=0 in STREAM cycle 2 -> sequencing=0 next cycle, full=0, and 4 further writes produce no burst.
